// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) round-robin arbiter onto one shared memory port,
// with a bounded wait for the memory acknowledge and per-requester read-data registers.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_w_i,
  input  logic        res_w_i_h,

  input  logic        if_req_w_i_h,
  input  logic [31:0] if_addr_w_i,
  output logic [31:0] if_rdata_w_o,
  output logic        if_done_w_o_h,

  input  logic        d_req_w_i_h,
  input  logic        d_wr_w_i_h,
  input  logic [31:0] d_addr_w_i,
  input  logic [31:0] d_wdata_w_i,
  input  logic [1:0]  d_byte_sel_w_i,
  output logic [31:0] d_rdata_w_o,
  output logic        d_done_w_o_h,

  output logic        mem_req_w_o_h,
  output logic        mem_wr_w_o_h,
  output logic [31:0] mem_addr_w_o,
  output logic [31:0] mem_data_w_o,
  output logic [1:0]  mem_byte_sel_w_o,
  input  logic [31:0] mem_data_w_i,
  input  logic        mem_ack_w_i_h,

  output logic        stall_w_o_h,
  output logic        err_w_o_h
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [4:0] WaitLimit = 5'(TIMEOUT - 1);
  localparam logic       GntFetch  = 1'b0;
  localparam logic       GntData   = 1'b1;
  localparam logic [1:0] BselWord  = 2'b10;

  state_e      state_q, state_d;
  logic [4:0]  wait_q, wait_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  bsel_q, bsel_d;
  logic        err_q, err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        grant_valid;
  logic        grant_id;
  logic        wait_expired;

  assign grant_valid  = if_req_w_i_h | d_req_w_i_h;
  assign wait_expired = (wait_q == WaitLimit);

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant_id = GntFetch;
    case ({if_req_w_i_h, d_req_w_i_h})
      2'b01:   grant_id = GntData;
      2'b11:   grant_id = ~last_q;
      default: grant_id = GntFetch;
    endcase
  end

  // State register
  always_ff @(posedge clk_w_i) begin
    if (res_w_i_h) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (grant_valid) state_d = StAccess;
      StAccess: if (mem_ack_w_i_h || wait_expired) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Access bookkeeping: grant latch, wait counter, read-data capture
  always_comb begin
    wait_d     = wait_q;
    last_d     = last_q;
    id_d       = id_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    bsel_d     = bsel_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          wait_d = 5'd0;
          err_d  = 1'b0;
          id_d   = grant_id;
          last_d = grant_id;
          if (grant_id == GntData) begin
            wr_d   = d_wr_w_i_h;
            addr_d = d_addr_w_i;
            data_d = d_wdata_w_i;
            bsel_d = d_byte_sel_w_i;
          end else begin
            wr_d   = 1'b0;
            addr_d = if_addr_w_i;
            data_d = 32'h0;
            bsel_d = BselWord;
          end
        end
      end
      StAccess: begin
        // An ack on the final wait cycle still wins over the timeout.
        if (mem_ack_w_i_h) begin
          if (!wr_q) begin
            if (id_q == GntData) d_rdata_d = mem_data_w_i;
            else                 if_rdata_d = mem_data_w_i;
          end
        end else if (wait_expired) begin
          err_d = 1'b1;
          if (id_q == GntData) d_rdata_d = 32'h0;
          else                 if_rdata_d = 32'h0;
        end else begin
          wait_d = wait_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_w_i) begin
    if (res_w_i_h) begin
      wait_q     <= 5'd0;
      last_q     <= GntFetch;
      id_q       <= GntFetch;
      wr_q       <= 1'b0;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      bsel_q     <= 2'b00;
      err_q      <= 1'b0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      wait_q     <= wait_d;
      last_q     <= last_d;
      id_q       <= id_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      bsel_q     <= bsel_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Outputs; everything is forced quiet while reset is held.
  always_comb begin
    mem_req_w_o_h    = 1'b0;
    mem_wr_w_o_h     = 1'b0;
    mem_addr_w_o     = 32'h0;
    mem_data_w_o     = 32'h0;
    mem_byte_sel_w_o = 2'b00;
    if_done_w_o_h    = 1'b0;
    d_done_w_o_h     = 1'b0;
    err_w_o_h        = 1'b0;
    if (!res_w_i_h) begin
      unique case (state_q)
        StAccess: begin
          mem_req_w_o_h    = 1'b1;
          mem_wr_w_o_h     = wr_q;
          mem_addr_w_o     = addr_q;
          mem_data_w_o     = data_q;
          mem_byte_sel_w_o = bsel_q;
        end
        StResp: begin
          if_done_w_o_h = (id_q == GntFetch);
          d_done_w_o_h  = (id_q == GntData);
          err_w_o_h     = err_q;
        end
        default: ;
      endcase
    end
  end

  assign if_rdata_w_o = if_rdata_q;
  assign d_rdata_w_o  = d_rdata_q;
  assign stall_w_o_h  = (if_req_w_i_h & ~if_done_w_o_h) | (d_req_w_i_h & ~d_done_w_o_h);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model of the two requesters and the
// memory decides grant order, access length, done/err and read data for every access.
module tb_mem_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic        clk_w_i = 1'b0;
  logic        res_w_i_h = 1'b1;
  logic        if_req_w_i_h = 1'b0;
  logic [31:0] if_addr_w_i = 32'h0;
  logic [31:0] if_rdata_w_o;
  logic        if_done_w_o_h;
  logic        d_req_w_i_h = 1'b0;
  logic        d_wr_w_i_h = 1'b0;
  logic [31:0] d_addr_w_i = 32'h0;
  logic [31:0] d_wdata_w_i = 32'h0;
  logic [1:0]  d_byte_sel_w_i = 2'b00;
  logic [31:0] d_rdata_w_o;
  logic        d_done_w_o_h;
  logic        mem_req_w_o_h;
  logic        mem_wr_w_o_h;
  logic [31:0] mem_addr_w_o;
  logic [31:0] mem_data_w_o;
  logic [1:0]  mem_byte_sel_w_o;
  logic [31:0] mem_data_w_i = 32'h0;
  logic        mem_ack_w_i_h = 1'b0;
  logic        stall_w_o_h;
  logic        err_w_o_h;

  always #5 clk_w_i = ~clk_w_i;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) u_dut (
    .clk_w_i          (clk_w_i),
    .res_w_i_h        (res_w_i_h),
    .if_req_w_i_h     (if_req_w_i_h),
    .if_addr_w_i      (if_addr_w_i),
    .if_rdata_w_o     (if_rdata_w_o),
    .if_done_w_o_h    (if_done_w_o_h),
    .d_req_w_i_h      (d_req_w_i_h),
    .d_wr_w_i_h       (d_wr_w_i_h),
    .d_addr_w_i       (d_addr_w_i),
    .d_wdata_w_i      (d_wdata_w_i),
    .d_byte_sel_w_i   (d_byte_sel_w_i),
    .d_rdata_w_o      (d_rdata_w_o),
    .d_done_w_o_h     (d_done_w_o_h),
    .mem_req_w_o_h    (mem_req_w_o_h),
    .mem_wr_w_o_h     (mem_wr_w_o_h),
    .mem_addr_w_o     (mem_addr_w_o),
    .mem_data_w_o     (mem_data_w_o),
    .mem_byte_sel_w_o (mem_byte_sel_w_o),
    .mem_data_w_i     (mem_data_w_i),
    .mem_ack_w_i_h    (mem_ack_w_i_h),
    .stall_w_o_h      (stall_w_o_h),
    .err_w_o_h        (err_w_o_h)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: pending requests, round-robin memory, per-requester read data.
  bit          m_pend_f, m_pend_d;
  logic [31:0] m_f_addr;
  bit          m_d_wr;
  logic [31:0] m_d_addr, m_d_wdata;
  logic [1:0]  m_d_bsel;
  bit          m_last_d;
  logic [31:0] m_if_rdata, m_d_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_w_i);
    #1;
  endtask

  task automatic check_stall(input string tag, input bit exp_if_done, input bit exp_d_done);
    #1;
    check(tag, 32'(stall_w_o_h),
          32'((if_req_w_i_h & ~exp_if_done) | (d_req_w_i_h & ~exp_d_done)));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req_w_o_h), 32'd0);
    check({tag, "_mem_wr"}, 32'(mem_wr_w_o_h), 32'd0);
    check({tag, "_done_err"}, {29'd0, if_done_w_o_h, d_done_w_o_h, err_w_o_h}, 32'd0);
  endtask

  task automatic check_rdata(input string tag);
    check({tag, "_if_rdata"}, if_rdata_w_o, m_if_rdata);
    check({tag, "_d_rdata"}, d_rdata_w_o, m_d_rdata);
  endtask

  task automatic post_fetch(input logic [31:0] addr);
    m_pend_f = 1'b1;
    m_f_addr = addr;
  endtask

  task automatic post_data(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] bsel);
    m_pend_d  = 1'b1;
    m_d_wr    = wr;
    m_d_addr  = addr;
    m_d_wdata = wdata;
    m_d_bsel  = bsel;
  endtask

  task automatic drive_reqs();
    if_req_w_i_h   = m_pend_f;
    if_addr_w_i    = m_f_addr;
    d_req_w_i_h    = m_pend_d;
    d_wr_w_i_h     = m_d_wr;
    d_addr_w_i     = m_d_addr;
    d_wdata_w_i    = m_d_wdata;
    d_byte_sel_w_i = m_d_bsel;
  endtask

  task automatic model_reset();
    m_pend_f   = 1'b0;
    m_pend_d   = 1'b0;
    m_last_d   = 1'b0;
    m_if_rdata = 32'h0;
    m_d_rdata  = 32'h0;
  endtask

  // Holds reset for a few cycles with noisy inputs, then leaves reset low in the next cycle.
  task automatic do_reset();
    res_w_i_h     = 1'b1;
    if_req_w_i_h  = 1'b1;
    d_req_w_i_h   = 1'b1;
    mem_ack_w_i_h = 1'b1;
    mem_data_w_i  = $urandom;
    step();
    step();
    check_quiet("rst");
    step();
    model_reset();
    check_rdata("rst");
    res_w_i_h     = 1'b0;
    if_req_w_i_h  = 1'b0;
    d_req_w_i_h   = 1'b0;
    mem_ack_w_i_h = 1'b0;
  endtask

  // One complete access starting in an idle cycle; ack arrives on wait cycle lat (none if
  // lat >= TIMEOUT). Ends in the idle cycle after the done pulse.
  task automatic serve(input int lat, input logic [31:0] ack_data, input bit force_drop);
    bit win_d;
    bit timed_out;
    int k;
    drive_reqs();
    mem_ack_w_i_h = 1'($urandom_range(0, 1));
    mem_data_w_i  = $urandom;
    check_quiet("idle");
    check_stall("idle_stall", 1'b0, 1'b0);
    win_d = m_pend_d && (!m_pend_f || !m_last_d);
    m_last_d = win_d;
    step();
    k = 0;
    timed_out = 1'b0;
    forever begin
      check("acc_mem_req", 32'(mem_req_w_o_h), 32'd1);
      check("acc_mem_wr", 32'(mem_wr_w_o_h), 32'(win_d && m_d_wr));
      check("acc_mem_addr", mem_addr_w_o, win_d ? m_d_addr : m_f_addr);
      check("acc_mem_bsel", 32'(mem_byte_sel_w_o), 32'(win_d ? m_d_bsel : 2'b10));
      if (win_d && m_d_wr) check("acc_mem_data", mem_data_w_o, m_d_wdata);
      check("acc_done_err", {29'd0, if_done_w_o_h, d_done_w_o_h, err_w_o_h}, 32'd0);
      // Disturb the winner's inputs; the latched access must not move.
      if (win_d) begin
        d_addr_w_i     = $urandom;
        d_wdata_w_i    = $urandom;
        d_byte_sel_w_i = 2'($urandom);
        d_wr_w_i_h     = 1'($urandom);
        if ((force_drop && k == 1) || $urandom_range(0, 7) == 0) d_req_w_i_h = 1'b0;
      end else begin
        if_addr_w_i = $urandom;
        if ((force_drop && k == 1) || $urandom_range(0, 7) == 0) if_req_w_i_h = 1'b0;
      end
      mem_ack_w_i_h = (k == lat);
      mem_data_w_i  = (k == lat) ? ack_data : $urandom;
      check_stall("acc_stall", 1'b0, 1'b0);
      if (k == lat) break;
      if (k == int'(TIMEOUT) - 1) begin
        timed_out = 1'b1;
        break;
      end
      k++;
      step();
    end
    step();
    mem_ack_w_i_h = 1'($urandom_range(0, 1));
    mem_data_w_i  = $urandom;
    check("resp_if_done", 32'(if_done_w_o_h), 32'(!win_d));
    check("resp_d_done", 32'(d_done_w_o_h), 32'(win_d));
    check("resp_err", 32'(err_w_o_h), 32'(timed_out));
    check("resp_mem_req", 32'(mem_req_w_o_h), 32'd0);
    check_stall("resp_stall", !win_d, win_d);
    if (timed_out) begin
      if (win_d) m_d_rdata = 32'h0;
      else       m_if_rdata = 32'h0;
    end else if (!(win_d && m_d_wr)) begin
      if (win_d) m_d_rdata = ack_data;
      else       m_if_rdata = ack_data;
    end
    if (win_d) m_pend_d = 1'b0;
    else       m_pend_f = 1'b0;
    step();
    check_rdata("post");
  endtask

  task automatic idle_cycle();
    drive_reqs();
    mem_ack_w_i_h = 1'($urandom_range(0, 1));
    mem_data_w_i  = $urandom;
    check_quiet("noreq");
    check_stall("noreq_stall", 1'b0, 1'b0);
    step();
    check("noreq_next_mem_req", 32'(mem_req_w_o_h), 32'd0);
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)  return $urandom_range(0, 3);
    if (r < 8)  return $urandom_range(4, TIMEOUT - 1);
    if (r == 8) return int'(TIMEOUT) - 1;
    return int'(TIMEOUT) + 5;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    m_f_addr  = 32'h0;
    m_d_wr    = 1'b0;
    m_d_addr  = 32'h0;
    m_d_wdata = 32'h0;
    m_d_bsel  = 2'b00;
    do_reset();

    // Single fetch straight out of reset, ack in the first access cycle.
    post_fetch(32'h100);
    serve(0, 32'h00500093, 1'b0);
    check("fetch_rdata", if_rdata_w_o, 32'h00500093);

    // Tie from reset: data store goes first, then the fetch.
    do_reset();
    post_fetch(32'h104);
    post_data(1'b1, 32'h2000, 32'hDEADBEEF, 2'b10);
    serve(0, $urandom, 1'b0);
    serve(0, $urandom, 1'b0);

    // Continuous dual requests: the model alternates D,F,D,F,D,F.
    for (int i = 0; i < 6; i++) begin
      if (!m_pend_f) post_fetch($urandom);
      if (!m_pend_d) post_data(1'($urandom), $urandom, $urandom, 2'($urandom));
      serve(0, $urandom, 1'b0);
    end
    // Leftover request from the alternation loop.
    while (m_pend_f || m_pend_d) serve(0, $urandom, 1'b0);

    // Load with no ack: full timeout, err, zeroed read data.
    post_data(1'b0, 32'h3000, 32'h0, 2'b10);
    serve(TIMEOUT + 3, 32'h0, 1'b0);
    check("timeout_d_rdata", d_rdata_w_o, 32'h0);

    // Ack on the very last wait cycle is a success.
    post_data(1'b0, 32'h3008, 32'h0, 2'b01);
    serve(TIMEOUT - 1, 32'hCAFEF00D, 1'b0);

    // Load acked after three wait cycles with the request dropped mid-access.
    post_data(1'b0, 32'h3004, 32'h0, 2'b10);
    serve(3, 32'h12345678, 1'b1);
    check("drop_d_rdata", d_rdata_w_o, 32'h12345678);

    // Reset in the second access cycle of a fetch; the late ack must be ignored.
    post_fetch(32'h200);
    drive_reqs();
    mem_ack_w_i_h = 1'b0;
    step();
    check("rstacc_mem_req1", 32'(mem_req_w_o_h), 32'd1);
    step();
    res_w_i_h = 1'b1;
    #1;
    check_quiet("rstacc_during");
    step();
    res_w_i_h     = 1'b0;
    if_req_w_i_h  = 1'b0;
    mem_ack_w_i_h = 1'b1;
    mem_data_w_i  = 32'hBADBAD00;
    model_reset();
    check_quiet("rstacc_after");
    check_rdata("rstacc_after");
    step();
    mem_ack_w_i_h = 1'b0;
    check_quiet("rstacc_after2");
    check_rdata("rstacc_after2");

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      if (!m_pend_f && $urandom_range(0, 1) == 1) post_fetch($urandom);
      if (!m_pend_d && $urandom_range(0, 1) == 1)
        post_data(1'($urandom), $urandom, $urandom, 2'($urandom));
      if (!m_pend_f && !m_pend_d) idle_cycle();
      else serve(pick_lat(), $urandom, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
